ball_motion: RTL and testbench
==============================

Name: ball_motion

Overview:
- Owns ball position, direction and speed for the pong table.
- Consumes the registered collision flags (coll_paddle, coll_wall) from the collision detector.
- Produces ball_h, ball_v, ball_dir and ball_speed, which feed both the collision detector and the video renderer.
- Advances once per frame tick, runs the serve/play/score sequence, and emits one-cycle score pulses to the scoreboard.

Parameters:
- TABLE_TOP, 16, top table edge in pixels.
- TABLE_BOTTOM, 464, bottom table edge in pixels.
- BALL_VSIZE, 8, ball height in pixels.
- START_H, 316, horizontal serve position.
- START_V, 236, vertical serve position.
- INIT_SPEED, 2, horizontal pixels per tick at serve.
- MAX_SPEED, 8, horizontal speed ceiling; must be ≤ 15.
- V_STEP, 1, vertical pixels per tick.
- SCORE_HOLD, 60, ticks the ball stays frozen after a score.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- tick  in  1  one-cycle frame strobe, one per frame
- serve  in  1  debounced serve request, level
- coll_paddle  in  1  paddle collision flag, registered upstream
- coll_wall  in  1  goal-wall collision flag, registered upstream
- ball_h  out  11  ball left edge x
- ball_v  out  11  ball top edge y
- ball_dir  out  1  horizontal direction (`LEFT=0, `RIGHT=1)
- ball_speed  out  4  horizontal pixels per tick
- in_play  out  1  high while state is PLAY
- score_left  out  1  one-cycle pulse: left player scores
- score_right  out  1  one-cycle pulse: right player scores

Behaviour:
- All state updates happen only on clk edges with tick=1. Exception: the score pulses, which clear on the next clk edge.
- Reset (asynchronous, any time, including mid-PLAY or mid-HOLD):
  - state=SERVE, ball_h=START_H, ball_v=START_V, ball_dir=`RIGHT, v_dir=down, ball_speed=INIT_SPEED.
  - hold counter=0, in_play=0, score pulses=0.
- States:
  - SERVE:
    - Ball held at START_H/START_V, ball_speed=INIT_SPEED.
    - On tick with serve=1 → PLAY; no movement on that tick.
  - PLAY, evaluated on each tick with priority coll_wall > coll_paddle > move:
    - coll_wall=1:
      - ball_dir=`RIGHT → score_left=1 for one clk; ball_dir=`LEFT → score_right=1 for one clk.
      - Position frozen; hold counter=0; → HOLD.
    - coll_paddle=1:
      - ball_dir inverts; ball_speed=min(ball_speed+1, MAX_SPEED).
      - ball_h unchanged this tick; vertical step still applies.
    - Otherwise:
      - ball_h = ball_h ± ball_speed, 11-bit unsigned, + for `RIGHT.
      - No clamping is done here; the wall flag guarantees no underflow in a legal table layout.
    - Vertical step, every PLAY tick:
      - Candidate v = ball_v ± V_STEP.
      - Moving up with candidate ≤ TABLE_TOP: ball_v=TABLE_TOP, v_dir=down.
      - Moving down with candidate+BALL_VSIZE ≥ TABLE_BOTTOM: ball_v=TABLE_BOTTOM−BALL_VSIZE, v_dir=up.
      - Top/bottom bounce is independent of, and simultaneous with, a paddle bounce.
  - HOLD:
    - Ball frozen; counter increments per tick.
    - When counter reaches SCORE_HOLD−1 → SERVE.
    - Position reset to START_H/START_V and ball_speed to INIT_SPEED.
    - ball_dir set toward the player who conceded: score_left → `RIGHT, score_right → `LEFT.
    - v_dir is kept.
- Collision flags are sampled only on tick cycles. They are registered one clk after position changes, so they are always settled by the next tick. Flags are ignored in SERVE and HOLD.
- in_play is a registered decode of state==PLAY.
- Score pulses never overlap.
- Outputs change only on clk edges; no combinational path from inputs to outputs.

Test Plan:
- Reset → serve: assert rst mid-PLAY at ball_h=400 → all outputs return to reset values immediately. Release rst, tick with serve=1 → in_play=1 and ball_h=316 on that tick; next tick → ball_h=318, ball_v=237.
- Paddle hit with speed saturation: in PLAY with ball_dir=`RIGHT, speed=8, pulse coll_paddle on a tick → ball_dir=`LEFT, speed stays 8, ball_h unchanged. Repeat from speed=3 → speed becomes 4.
- Top wall bounce: ball_v=17 moving up, V_STEP=1 → ball_v=16 and v_dir=down; next tick → ball_v=17.
- Goal, hold and re-serve: coll_wall=1 with ball_dir=`LEFT → score_right high exactly one clk, state HOLD. 60 ticks later → SERVE with ball at 316/236, speed=2, ball_dir=`LEFT.
- Simultaneous coll_wall and coll_paddle → wall wins: score pulse fires, direction unchanged, no speed increment.
- Flags ignored outside PLAY: assert coll_wall/coll_paddle and tick without serve in SERVE → no score pulse, position unchanged.

Source files
------------

// File: rtl/ball_motion.sv
`default_nettype none
// ============================================================================
// Module      : ball_motion
// Description : Pong ball kinematics. Holds ball position, direction and
//               speed; steps once per frame tick through the serve / play /
//               score-hold sequence and emits one-cycle score pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module ball_motion #(
    parameter int TABLE_TOP    = 16,
    parameter int TABLE_BOTTOM = 464,
    parameter int BALL_VSIZE   = 8,
    parameter int START_H      = 316,
    parameter int START_V      = 236,
    parameter int INIT_SPEED   = 2,
    parameter int MAX_SPEED    = 8,
    parameter int V_STEP       = 1,
    parameter int SCORE_HOLD   = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        serve,
    input  logic        coll_paddle,
    input  logic        coll_wall,
    output logic [10:0] ball_h,
    output logic [10:0] ball_v,
    output logic        ball_dir,
    output logic [3:0]  ball_speed,
    output logic        in_play,
    output logic        score_left,
    output logic        score_right
);

    localparam int CNT_W = (SCORE_HOLD > 1) ? $clog2(SCORE_HOLD) : 1;

    localparam logic        DIR_LEFT   = 1'b0;
    localparam logic        DIR_RIGHT  = 1'b1;
    localparam logic [10:0] START_H_L  = 11'(START_H);
    localparam logic [10:0] START_V_L  = 11'(START_V);
    localparam logic [3:0]  INIT_SPD_L = 4'(INIT_SPEED);
    localparam logic [3:0]  MAX_SPD_L  = 4'(MAX_SPEED);
    localparam logic [11:0] V_STEP_L   = 12'(V_STEP);
    localparam logic [11:0] TOP_L      = 12'(TABLE_TOP);
    localparam logic [11:0] BOTTOM_L   = 12'(TABLE_BOTTOM);
    localparam logic [11:0] VSIZE_L    = 12'(BALL_VSIZE);
    localparam logic [10:0] V_LOW_L    = 11'(TABLE_BOTTOM - BALL_VSIZE);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SCORE_HOLD - 1);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [10:0]        h_nxt, v_nxt;
    logic               dir_nxt;
    logic               v_up, v_up_nxt;
    logic [3:0]         spd_nxt;
    logic [CNT_W-1:0]   hold_cnt, cnt_nxt;
    logic               sl_nxt, sr_nxt;
    logic [11:0]        v_cand;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_SERVE;
        else     state <= state_nxt;
    end

    // Next-state and datapath decode; everything holds unless tick is high
    always_comb begin
        state_nxt = state;
        h_nxt     = ball_h;
        v_nxt     = ball_v;
        dir_nxt   = ball_dir;
        v_up_nxt  = v_up;
        spd_nxt   = ball_speed;
        cnt_nxt   = hold_cnt;
        sl_nxt    = 1'b0;
        sr_nxt    = 1'b0;
        v_cand    = '0;
        if (tick) begin
            case (state)
                ST_SERVE: begin
                    if (serve) state_nxt = ST_PLAY;
                end
                ST_PLAY: begin
                    if (coll_wall) begin
                        // Ball went out on the side it was travelling toward
                        if (ball_dir == DIR_RIGHT) sl_nxt = 1'b1;
                        else                       sr_nxt = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_HOLD;
                    end else begin
                        if (coll_paddle) begin
                            dir_nxt = ~ball_dir;
                            spd_nxt = (ball_speed >= MAX_SPD_L) ? MAX_SPD_L
                                                                : ball_speed + 4'd1;
                        end else if (ball_dir == DIR_RIGHT) begin
                            h_nxt = ball_h + {7'd0, ball_speed};
                        end else begin
                            h_nxt = ball_h - {7'd0, ball_speed};
                        end
                        // Vertical step with top/bottom reflection
                        if (v_up) begin
                            v_cand = {1'b0, ball_v} - V_STEP_L;
                            if (v_cand <= TOP_L) begin
                                v_nxt    = TOP_L[10:0];
                                v_up_nxt = 1'b0;
                            end else begin
                                v_nxt = v_cand[10:0];
                            end
                        end else begin
                            v_cand = {1'b0, ball_v} + V_STEP_L;
                            if (v_cand + VSIZE_L >= BOTTOM_L) begin
                                v_nxt    = V_LOW_L;
                                v_up_nxt = 1'b1;
                            end else begin
                                v_nxt = v_cand[10:0];
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    // ball_dir is untouched since the goal, so it already
                    // points at the player who conceded
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = ST_SERVE;
                        h_nxt     = START_H_L;
                        v_nxt     = START_V_L;
                        spd_nxt   = INIT_SPD_L;
                    end else begin
                        cnt_nxt = hold_cnt + 1'b1;
                    end
                end
                default: state_nxt = ST_SERVE;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ball_h      <= START_H_L;
            ball_v      <= START_V_L;
            ball_dir    <= DIR_RIGHT;
            v_up        <= 1'b0;
            ball_speed  <= INIT_SPD_L;
            hold_cnt    <= '0;
            in_play     <= 1'b0;
            score_left  <= 1'b0;
            score_right <= 1'b0;
        end else begin
            ball_h      <= h_nxt;
            ball_v      <= v_nxt;
            ball_dir    <= dir_nxt;
            v_up        <= v_up_nxt;
            ball_speed  <= spd_nxt;
            hold_cnt    <= cnt_nxt;
            in_play     <= (state_nxt == ST_PLAY);
            score_left  <= sl_nxt;
            score_right <= sr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ball_motion.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_motion
// Description : Self-checking bench for ball_motion with a behavioural model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_motion;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0, serve = 1'b0, coll_paddle = 1'b0, coll_wall = 1'b0;
    logic [10:0] ball_h, ball_v;
    logic        ball_dir;
    logic [3:0]  ball_speed;
    logic        in_play, score_left, score_right;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: game phase, position, motion
    string m_phase;
    int    m_h, m_v, m_dir, m_up, m_spd, m_hold, m_sl, m_sr;

    ball_motion dut (
        .clk(clk), .rst(rst), .tick(tick), .serve(serve),
        .coll_paddle(coll_paddle), .coll_wall(coll_wall),
        .ball_h(ball_h), .ball_v(ball_v), .ball_dir(ball_dir),
        .ball_speed(ball_speed), .in_play(in_play),
        .score_left(score_left), .score_right(score_right)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = "SERVE";
        m_h = 316; m_v = 236; m_dir = 1; m_up = 0; m_spd = 2;
        m_hold = 0; m_sl = 0; m_sr = 0;
    endtask

    // One clock of the game rules
    task automatic model_step(input bit t, input bit s, input bit p, input bit w);
        m_sl = 0; m_sr = 0;
        if (!t) return;
        if (m_phase == "SERVE") begin
            if (s) m_phase = "PLAY";
        end else if (m_phase == "PLAY") begin
            if (w) begin
                if (m_dir == 1) m_sl = 1; else m_sr = 1;
                m_phase = "HOLD";
                m_hold = 0;
            end else begin
                if (p) begin
                    m_dir = 1 - m_dir;
                    m_spd = (m_spd + 1 > 8) ? 8 : m_spd + 1;
                end else if (m_dir == 1) m_h = (m_h + m_spd) % 2048;
                else                     m_h = (m_h - m_spd + 2048) % 2048;
                if (m_up == 1) begin
                    if (m_v - 1 <= 16) begin m_v = 16; m_up = 0; end
                    else m_v = m_v - 1;
                end else begin
                    if (m_v + 1 + 8 >= 464) begin m_v = 456; m_up = 1; end
                    else m_v = m_v + 1;
                end
            end
        end else begin
            m_hold++;
            if (m_hold == 60) begin
                m_phase = "SERVE";
                m_h = 316; m_v = 236; m_spd = 2;
            end
        end
    endtask

    task automatic check_all();
        chk("ball_h",      32'(ball_h),      32'(m_h));
        chk("ball_v",      32'(ball_v),      32'(m_v));
        chk("ball_dir",    32'(ball_dir),    32'(m_dir));
        chk("ball_speed",  32'(ball_speed),  32'(m_spd));
        chk("in_play",     32'(in_play),     32'(m_phase == "PLAY"));
        chk("score_left",  32'(score_left),  32'(m_sl));
        chk("score_right", 32'(score_right), 32'(m_sr));
        chk("no_overlap",  32'(score_left & score_right), 32'd0);
    endtask

    task automatic cyc(input bit t, input bit s, input bit p, input bit w);
        @(negedge clk);
        tick = t; serve = s; coll_paddle = p; coll_wall = w;
        @(posedge clk);
        model_step(t, s, p, w);
        #1;
        check_all();
    endtask

    initial begin
        int  dir_before;
        bit  found;

        // Reset values
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) rst = 1'b0;

        // Serve: no motion on the serve tick, then one step
        cyc(1, 1, 0, 0);
        chk("serve_h", 32'(ball_h), 32'd316);
        chk("serve_inplay", 32'(in_play), 32'd1);
        cyc(1, 0, 0, 0);
        chk("step_h", 32'(ball_h), 32'd318);
        chk("step_v", 32'(ball_v), 32'd237);
        repeat (41) cyc(1, 0, 0, 0);
        chk("pre_rst_h", 32'(ball_h), 32'd400);

        // Asynchronous reset mid-play, observed before any clock edge
        @(negedge clk);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk) rst = 1'b0;

        // Paddle hits: speed climbs to 8 and saturates
        cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0);
        chk("speed_3_to_4", 32'(ball_speed), 32'd4);
        repeat (4) cyc(1, 0, 1, 0);
        chk("speed_at_8", 32'(ball_speed), 32'd8);
        chk("dir_right", 32'(ball_dir), 32'd1);
        cyc(1, 0, 1, 0);
        chk("sat_speed", 32'(ball_speed), 32'd8);
        chk("sat_dir", 32'(ball_dir), 32'd0);
        chk("sat_h", 32'(ball_h), 32'd316);

        // Ride the paddle until the ball is at v=17 moving up
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (m_v == 17 && m_up == 1) found = 1;
            else cyc(1, 0, 1, 0);
        end
        chk("top_reached", 32'(found), 32'd1);
        cyc(1, 0, 1, 0);
        chk("top_clamp", 32'(ball_v), 32'd16);
        cyc(1, 0, 1, 0);
        chk("top_rebound", 32'(ball_v), 32'd17);

        // Goal on the left wall, hold, re-serve toward the conceder
        if (m_dir == 1) cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 1);
        chk("goal_sr", 32'(score_right), 32'd1);
        chk("goal_sl", 32'(score_left), 32'd0);
        cyc(0, 0, 0, 0);
        chk("goal_sr_clear", 32'(score_right), 32'd0);
        repeat (59) cyc(1, 1, 1, 1);
        cyc(1, 0, 0, 0);
        chk("reserve_h", 32'(ball_h), 32'd316);
        chk("reserve_v", 32'(ball_v), 32'd236);
        chk("reserve_spd", 32'(ball_speed), 32'd2);
        chk("reserve_dir", 32'(ball_dir), 32'd0);
        chk("reserve_inplay", 32'(in_play), 32'd0);

        // Wall and paddle together: wall wins
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        dir_before = m_dir;
        cyc(1, 0, 1, 1);
        chk("both_dir", 32'(ball_dir), 32'(dir_before));
        chk("both_spd", 32'(ball_speed), 32'd2);
        chk("both_pulse", 32'(score_left | score_right), 32'd1);
        repeat (60) cyc(1, 0, 0, 0);

        // Flags ignored in SERVE
        cyc(1, 0, 1, 1);
        chk("serve_ign_pulse", 32'(score_left | score_right), 32'd0);
        chk("serve_ign_h", 32'(ball_h), 32'd316);

        // Randomized play
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);

        @(negedge clk);
        tick = 0; serve = 0; coll_paddle = 0; coll_wall = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
